// File: rtl/window_shift_buffer.sv
// ROWS x COLS window register table: whole-table load, or one-line row/column shift per cycle.
// Reads are combinational with zero latency. Priority is rst > clr > ld > shift, and the block never stalls.
module window_shift_buffer #(
    parameter  int ROWS = 4,
    parameter  int COLS = 4,
    parameter  int DW   = 8,
    localparam int RW   = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1,
    localparam int CW   = ($clog2(COLS) > 1) ? $clog2(COLS) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     ld_i,
    input  logic [ROWS*COLS*DW-1:0]  in_i,
    input  logic                     shift_i,
    input  logic                     dir_i,
    input  logic [COLS*DW-1:0]       row_in_i,
    input  logic [ROWS*DW-1:0]       col_in_i,
    input  logic [RW-1:0]            row_i,
    input  logic [CW-1:0]            col_i,
    output logic [DW-1:0]            out_o,
    output logic                     out_vld_o,
    output logic [ROWS*COLS*DW-1:0]  table_out_o,
    output logic                     full_o
);

    logic [DW-1:0] data_q [ROWS][COLS];
    logic [DW-1:0] data_d [ROWS][COLS];
    logic          vld_q  [ROWS][COLS];
    logic          vld_d  [ROWS][COLS];

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (clr_i) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    data_d[r][c] = '0;
                    vld_d[r][c]  = 1'b0;
                end
            end
        end else if (ld_i) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    data_d[r][c] = in_i[(ROWS*COLS-1-(r*COLS+c))*DW +: DW];
                    vld_d[r][c]  = 1'b1;
                end
            end
        end else if (shift_i && !dir_i) begin
            // Vertical slide: row 0 falls off the top, the new line enters at the bottom.
            for (int r = 0; r < ROWS-1; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    data_d[r][c] = data_q[r+1][c];
                    vld_d[r][c]  = vld_q[r+1][c];
                end
            end
            for (int c = 0; c < COLS; c++) begin
                data_d[ROWS-1][c] = row_in_i[(COLS-1-c)*DW +: DW];
                vld_d[ROWS-1][c]  = 1'b1;
            end
        end else if (shift_i) begin
            // Horizontal slide: column 0 falls off the left, the new line enters at the right.
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS-1; c++) begin
                    data_d[r][c] = data_q[r][c+1];
                    vld_d[r][c]  = vld_q[r][c+1];
                end
                data_d[r][COLS-1] = col_in_i[(ROWS-1-r)*DW +: DW];
                vld_d[r][COLS-1]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    data_q[r][c] <= '0;
                    vld_q[r][c]  <= 1'b0;
                end
            end
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    // Decoded mux: an index with no matching element leaves the zero defaults in place.
    always_comb begin
        out_o       = '0;
        out_vld_o   = 1'b0;
        table_out_o = '0;
        full_o      = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (row_i == RW'(r) && col_i == CW'(c)) begin
                    out_o     = data_q[r][c];
                    out_vld_o = vld_q[r][c];
                end
                table_out_o[(ROWS*COLS-1-(r*COLS+c))*DW +: DW] = data_q[r][c];
                full_o = full_o & vld_q[r][c];
            end
        end
    end

endmodule
